// File: rtl/hyst_controller.sv
// Hysteresis threshold stage: classifies a 12-pixel magnitude segment into strong/weak,
// grows weak pixels along their gradient direction, and emits a 10-pixel binary edge row.
module hyst_controller #(
  parameter int HIGH_THRESH = 150,
  parameter int LOW_THRESH  = 50,
  parameter int MAX_PASSES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             anchor_moving,
  input  logic [11:0][1:0] gradient_angle,
  input  logic [11:0][7:0] hyst_in,
  output logic [9:0][7:0]  hyst_out,
  output logic             hyst_final
);

  localparam int PW = $clog2(MAX_PASSES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIFY,
    S_PROPAGATE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [10:1][1:0] r_angle;
  logic [11:0][7:0] r_mag;
  logic [11:0]      r_edge;
  logic [10:1]      r_weak;
  logic [9:0]       r_prev_edge;
  logic [PW-1:0]    r_pass_cnt;
  logic [9:0][7:0]  r_hyst_out;
  logic             r_hyst_final;

  logic [11:0]      w_strong;
  logic [10:1]      w_weak;
  logic [11:0]      w_edge_pass;
  logic [11:0]      w_prev_col;
  logic [9:0][7:0]  w_out_bytes;
  logic             w_settled;
  logic             w_pass_last;
  logic             w_unused;

  // Context-pixel angles carry no meaning: only their strong/none class is used.
  assign w_unused = &{1'b0, gradient_angle[0], gradient_angle[11]};

  // Row-above edge map indexed by column; the outer columns have no stored result.
  assign w_prev_col = {1'b0, r_prev_edge, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_strong
      assign w_strong[gi] = (r_mag[gi] >= 8'(HIGH_THRESH));
    end

    for (gi = 1; gi <= 10; gi++) begin : g_weak
      assign w_weak[gi] = (r_mag[gi] >= 8'(LOW_THRESH)) && !w_strong[gi];
    end

    for (gi = 1; gi <= 10; gi++) begin : g_prop
      logic w_nb;
      always_comb begin
        w_nb = 1'b0;
        case (r_angle[gi])
          2'd0:    w_nb = r_edge[gi-1] | r_edge[gi+1];
          2'd1:    w_nb = w_prev_col[gi+1];
          2'd2:    w_nb = w_prev_col[gi];
          default: w_nb = w_prev_col[gi-1];
        endcase
      end
      assign w_edge_pass[gi] = r_edge[gi] | (r_weak[gi] & w_nb);
    end

    for (gi = 0; gi < 10; gi++) begin : g_out
      assign w_out_bytes[gi] = w_edge_pass[gi+1] ? 8'd255 : 8'd0;
    end
  endgenerate

  assign w_edge_pass[0]  = r_edge[0];
  assign w_edge_pass[11] = r_edge[11];

  // Each pass reads only the previous pass's map, so a chain grows one pixel per cycle.
  assign w_settled   = (w_edge_pass == r_edge);
  assign w_pass_last = (r_pass_cnt == PW'(MAX_PASSES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (anchor_moving) w_state_next = S_CLASSIFY;
      S_CLASSIFY:  w_state_next = S_PROPAGATE;
      S_PROPAGATE: if (w_settled || w_pass_last) w_state_next = S_DONE;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_angle      <= '0;
      r_mag        <= '0;
      r_edge       <= '0;
      r_weak       <= '0;
      r_pass_cnt   <= '0;
      r_prev_edge  <= '0;
      r_hyst_out   <= '0;
      r_hyst_final <= 1'b0;
    end else begin
      // Results are loaded on the final pass so they are already valid while in DONE.
      r_hyst_final <= (r_state == S_PROPAGATE) && (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (anchor_moving) begin
            r_angle <= gradient_angle[10:1];
            r_mag   <= hyst_in;
          end
        end
        S_CLASSIFY: begin
          r_edge     <= w_strong;
          r_weak     <= w_weak;
          r_pass_cnt <= '0;
        end
        S_PROPAGATE: begin
          r_edge     <= w_edge_pass;
          r_pass_cnt <= r_pass_cnt + 1'b1;
          if (w_state_next == S_DONE) begin
            r_hyst_out  <= w_out_bytes;
            r_prev_edge <= w_edge_pass[10:1];
          end
        end
        default: ;
      endcase
    end
  end

  assign hyst_out   = r_hyst_out;
  assign hyst_final = r_hyst_final;

endmodule

// File: tb/tb_hyst_controller.sv
// Directed bench for hyst_controller: threshold classes, row-above linkage,
// angle-0 chaining, index boundaries, strobe filtering and mid-segment reset.
module tb_hyst_controller;

  typedef logic [11:0][1:0] ang_t;
  typedef logic [11:0][7:0] mag_t;
  typedef logic [9:0][7:0]  out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic anchor_moving = 1'b0;
  ang_t gradient_angle = '0;
  mag_t hyst_in = '0;
  out_t hyst_out;
  logic hyst_final;

  int n_pass  = 0;
  int n_total = 0;

  out_t seg_out;
  int   seg_lat;
  int   seg_pulses;

  hyst_controller dut (
    .clk            (clk),
    .rst            (rst),
    .anchor_moving  (anchor_moving),
    .gradient_angle (gradient_angle),
    .hyst_in        (hyst_in),
    .hyst_out       (hyst_out),
    .hyst_final     (hyst_final)
  );

  always #5 clk = ~clk;

  function automatic ang_t fill_ang(input logic [1:0] v);
    ang_t a;
    for (int i = 0; i < 12; i++) a[i] = v;
    return a;
  endfunction

  function automatic mag_t fill_mag(input logic [7:0] v);
    mag_t m;
    for (int i = 0; i < 12; i++) m[i] = v;
    return m;
  endfunction

  function automatic out_t fill_out(input logic [7:0] v);
    out_t o;
    for (int i = 0; i < 10; i++) o[i] = v;
    return o;
  endfunction

  // One-cycle strobe, then watch a fixed window, recording the first result and pulse count.
  task automatic run_segment(input ang_t a, input mag_t m);
    @(negedge clk);
    gradient_angle = a;
    hyst_in        = m;
    anchor_moving  = 1'b1;
    seg_lat    = -1;
    seg_pulses = 0;
    seg_out    = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      anchor_moving = 1'b0;
      if (hyst_final) begin
        if (seg_pulses == 0) begin
          seg_lat = c;
          seg_out = hyst_out;
        end
        seg_pulses++;
      end
    end
    $display("segment: latency=%0d pulses=%0d out=%h", seg_lat, seg_pulses, seg_out);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (hyst_out !== '0) $display("FAIL reset_out: got %h expected 0", hyst_out);
    else n_pass++;
    n_total++;
    if (hyst_final !== 1'b0) $display("FAIL reset_final: got %b expected 0", hyst_final);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: out=%h final=%b", hyst_out, hyst_final);
  endtask

  task automatic test_suppressed();
    run_segment(fill_ang(2'd2), fill_mag(8'd30));
    n_total++;
    if (seg_pulses !== 1) $display("FAIL none_pulses: got %0d expected 1", seg_pulses);
    else n_pass++;
    n_total++;
    if (seg_out !== '0) $display("FAIL none_out: got %h expected 0", seg_out);
    else n_pass++;
    n_total++;
    if (seg_lat !== 3) $display("FAIL none_latency: got %0d expected 3", seg_lat);
    else n_pass++;
  endtask

  task automatic test_weak_isolated();
    run_segment(fill_ang(2'd2), fill_mag(8'd100));
    n_total++;
    if (seg_pulses !== 1 || seg_out !== '0)
      $display("FAIL weak_isolated: got pulses=%0d out=%h expected 1 / 0", seg_pulses, seg_out);
    else n_pass++;
  endtask

  task automatic test_strong();
    run_segment(fill_ang(2'd2), fill_mag(8'd200));
    n_total++;
    if (seg_pulses !== 1 || seg_out !== fill_out(8'd255))
      $display("FAIL strong: got pulses=%0d out=%h expected 1 / all ff", seg_pulses, seg_out);
    else n_pass++;
  endtask

  task automatic test_weak_connected();
    run_segment(fill_ang(2'd2), fill_mag(8'd100));
    n_total++;
    if (seg_pulses !== 1 || seg_out !== fill_out(8'd255))
      $display("FAIL weak_connected: got pulses=%0d out=%h expected 1 / all ff", seg_pulses, seg_out);
    else n_pass++;
  endtask

  task automatic test_back_to_none();
    run_segment(fill_ang(2'd2), fill_mag(8'd30));
    n_total++;
    if (seg_pulses !== 1 || seg_out !== '0)
      $display("FAIL back_to_none: got pulses=%0d out=%h expected 1 / 0", seg_pulses, seg_out);
    else n_pass++;
  endtask

  task automatic test_thresholds();
    mag_t m;
    out_t exp;
    m = '0;
    m[1] = 8'd150; m[2] = 8'd149; m[4] = 8'd49; m[5] = 8'd150;
    m[6] = 8'd50;  m[7] = 8'd49;  m[9] = 8'd100; m[10] = 8'd100; m[11] = 8'd200;
    exp = '0;
    exp[0] = 8'd255; exp[1] = 8'd255; exp[4] = 8'd255; exp[5] = 8'd255;
    exp[8] = 8'd255; exp[9] = 8'd255;
    run_segment(fill_ang(2'd0), m);
    n_total++;
    if (seg_out !== exp) $display("FAIL thresholds: got %h expected %h", seg_out, exp);
    else n_pass++;
  endtask

  task automatic test_chain();
    mag_t m;
    m = fill_mag(8'd100);
    m[0]  = 8'd0;
    m[1]  = 8'd200;
    m[11] = 8'd0;
    run_segment(fill_ang(2'd0), m);
    n_total++;
    if (seg_out !== fill_out(8'd255))
      $display("FAIL chain_out: got %h expected all ff", seg_out);
    else n_pass++;
    n_total++;
    if (seg_lat !== 12) $display("FAIL chain_latency: got %0d expected 12", seg_lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    out_t got;
    pulses = 0;
    got = '0;
    @(negedge clk);
    gradient_angle = fill_ang(2'd2);
    hyst_in        = fill_mag(8'd200);
    anchor_moving  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    anchor_moving = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (hyst_final) begin
        pulses++;
        got = hyst_out;
      end
    end
    $display("back_to_back: pulses=%0d out=%h", pulses, got);
    n_total++;
    if (pulses !== 1) $display("FAIL back_to_back_pulses: got %0d expected 1", pulses);
    else n_pass++;
    n_total++;
    if (got !== fill_out(8'd255)) $display("FAIL back_to_back_out: got %h expected all ff", got);
    else n_pass++;
  endtask

  task automatic test_diag_bounds();
    ang_t a;
    out_t exp;
    a = fill_ang(2'd2);
    a[1] = 2'd3; a[2] = 2'd1; a[3] = 2'd2; a[4] = 2'd3; a[5] = 2'd1;
    a[6] = 2'd2; a[7] = 2'd3; a[8] = 2'd1; a[9] = 2'd2; a[10] = 2'd1;
    exp = fill_out(8'd255);
    exp[0] = 8'd0;
    exp[9] = 8'd0;
    run_segment(a, fill_mag(8'd100));
    n_total++;
    if (seg_out !== exp) $display("FAIL diag_bounds: got %h expected %h", seg_out, exp);
    else n_pass++;
  endtask

  task automatic test_prev_readback();
    out_t exp;
    exp = fill_out(8'd255);
    exp[0] = 8'd0;
    exp[9] = 8'd0;
    run_segment(fill_ang(2'd2), fill_mag(8'd100));
    n_total++;
    if (seg_out !== exp) $display("FAIL prev_readback: got %h expected %h", seg_out, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mag_t m;
    int pulses;
    m = fill_mag(8'd100);
    m[0]  = 8'd0;
    m[1]  = 8'd200;
    m[11] = 8'd0;
    pulses = 0;
    @(negedge clk);
    gradient_angle = fill_ang(2'd0);
    hyst_in        = m;
    anchor_moving  = 1'b1;
    @(negedge clk);
    anchor_moving = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (hyst_out !== '0) $display("FAIL reset_mid_out: got %h expected 0", hyst_out);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (hyst_final) pulses++;
    end
    $display("reset_mid: pulses=%0d out=%h", pulses, hyst_out);
    n_total++;
    if (pulses !== 0) $display("FAIL reset_mid_pulses: got %0d expected 0", pulses);
    else n_pass++;
    run_segment(fill_ang(2'd2), fill_mag(8'd100));
    n_total++;
    if (seg_pulses !== 1 || seg_out !== '0)
      $display("FAIL reset_mid_prev_cleared: got pulses=%0d out=%h expected 1 / 0", seg_pulses, seg_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_suppressed();
    test_weak_isolated();
    test_strong();
    test_weak_connected();
    test_back_to_none();
    test_thresholds();
    test_chain();
    test_back_to_back();
    test_diag_bounds();
    test_prev_readback();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
